uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
Parametrised boot loader that turns a UART byte stream into program-memory writes. It holds the core while loading, then releases it.
- Generalises the fixed 32-bit flash sequence: configurable word width, byte order, memory depth and base address.
- Adds a length header, range check, inter-byte timeout and an optional checksum.
- Sits between the UART receiver and the program memory write port, alongside the fetch stage.

Parameters:
WORD_W, 32, instruction word width in bits; must be a multiple of 8, range 8..64
DEPTH, 1024, program memory depth in words
ADDR_W, 32, width of mem_addr (byte address)
BASE_ADDR, 0, byte address of the first written word
BIG_ENDIAN, 1, 1: first received byte of a word is its MSB; 0: first byte is its LSB
LEN_BYTES, 2, number of header bytes carrying the word count, little-endian, range 1..4
TIMEOUT_CYCLES, 0, maximum idle cycles between bytes once the header has started; 0 disables the timeout

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse that begins a load session
rx_data  input  8  received UART byte
rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
mem_clear  output  1  one-cycle pulse that clears program memory
mem_we  output  1  one-cycle word write strobe
mem_addr  output  ADDR_W  byte address for the write
mem_wdata  output  WORD_W  write data
core_hold  output  1  high while loading; keeps the PC at 0
busy  output  1  high in every state except IDLE
done  output  1  sticky; load completed successfully
error  output  1  sticky; load failed
words_written  output  32  count of words committed in the current session

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters, shift register and checksum 0.
- IDLE:
  - start=1 clears done, error and words_written, then goes to CLEAR.
  - rx_valid in IDLE is ignored.
- CLEAR: exactly one cycle. mem_clear=1, core_hold=1, then go to HEADER. An rx_valid during CLEAR is dropped.
- HEADER:
  - Collect LEN_BYTES bytes; byte i fills bits [8i+7:8i] of len.
  - After the last header byte:
    - len==0 -> DONE.
    - len>DEPTH -> ERROR.
    - otherwise -> DATA.
- DATA:
  - Each rx_valid shifts a byte into the word register.
  - BIG_ENDIAN=1: the register shifts left by 8 and the byte enters the LSB, so the first byte ends up as the MSB.
  - BIG_ENDIAN=0: the byte is placed at bits [8k+7:8k], where k is the byte index within the word.
  - On the cycle after the WORD_W/8-th byte:
    - mem_we=1 for one cycle; mem_wdata holds the assembled word.
    - mem_addr = BASE_ADDR + words_written*(WORD_W/8), truncated to ADDR_W.
    - words_written increments in the same cycle.
  - When words_written reaches len: go to CHECK if the macro is defined, otherwise DONE.
  - A byte arriving in the same cycle as a write pulse is accepted into the next word; no byte is lost.
- DONE / ERROR:
  - core_hold deasserts the same cycle the FSM leaves DATA/CHECK.
  - done or error is set and held.
  - Return to IDLE on the next cycle; busy=0 from then on.
- Timeout: active only when TIMEOUT_CYCLES!=0, in HEADER (after its first byte), DATA and CHECK.
  - A counter clears on each rx_valid.
  - When it reaches TIMEOUT_CYCLES: go to ERROR; a partially assembled word is not written.
- Other events:
  - start while busy is ignored.
  - rst mid-session aborts immediately: core_hold=0, no further mem_we.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all DATA bytes is kept.
  - After the last word, the CHECK state waits for one byte.
  - byte==sum -> DONE; otherwise ERROR. Words already written stay in memory.
- Undefined:
  - No CHECK state and no checksum logic.
  - DATA goes directly to DONE.
  - A trailing byte after the load arrives in IDLE and is ignored.

Test Plan:
- Defaults, start then bytes 02 00, 12 34 56 78, AA BB CC DD -> mem_clear pulse; writes 0x12345678@0 and 0xAABBCCDD@4; done=1; words_written=2.
- BIG_ENDIAN=0, same stream -> writes 0x78563412@0 and 0xDDCCBBAA@4.
- Header 00 00 -> no mem_we; done=1 three cycles after the second header byte; core_hold low again.
- DEPTH=4, header 05 00 -> error=1; no mem_we.
- TIMEOUT_CYCLES=100, header 01 00, then 2 data bytes, then silence -> error=1 exactly 100 cycles after the last byte; no mem_we.
- LOADER_CHECKSUM_EN defined, one word 01 02 03 04 then checksum 0A -> done=1; with checksum 0B -> error=1, and word 0x01020304 is still written.

Source files
------------

// File: rtl/uart_program_loader_if.sv
// rtl/uart_program_loader_if.sv - UART byte input and program-memory write bus of the loader
interface uart_program_loader_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_clear;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output mem_clear, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  mem_clear, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART boot loader writing program memory; optional checksum via LOADER_CHECKSUM_EN
module uart_program_loader #(
    parameter int          WORD_W         = 32,
    parameter int          DEPTH          = 1024,
    parameter int          ADDR_W         = 32,
    parameter logic [63:0] BASE_ADDR      = 64'd0,
    parameter bit          BIG_ENDIAN     = 1'b1,
    parameter int          LEN_BYTES      = 2,
    parameter int          TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    uart_program_loader_if.master bus,
    output logic                  core_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [31:0]           words_written_o
);
    localparam int NB = WORD_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_HEADER,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q;
    logic [31:0]       len_q, ww_q, tmo_q;
    logic [2:0]        hdr_idx_q;
    logic [3:0]        byte_idx_q;
    logic [WORD_W-1:0] word_q, wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mem_clear_q, mem_we_q, core_hold_q, busy_q, done_q, error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    logic [WORD_W-1:0] word_d;
    logic [31:0]       len_d;
    logic [ADDR_W-1:0] addr_d;
    logic              tmo_hit;

    // Word/length value after absorbing the current byte, next write address and idle-limit hit
    always_comb begin
        if (BIG_ENDIAN) begin
            word_d = (word_q << 8) | WORD_W'(bus.rx_data);
        end else begin
            word_d = word_q | (WORD_W'(bus.rx_data) << (8 * byte_idx_q));
        end
        len_d   = len_q | (32'(bus.rx_data) << (8 * hdr_idx_q));
        addr_d  = ADDR_W'(BASE_ADDR + 64'(ww_q) * 64'(NB));
        tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q + 32'd1 == 32'(TIMEOUT_CYCLES));
    end

    // Session state machine; every output is a register updated on the transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            ww_q        <= '0;
            tmo_q       <= '0;
            hdr_idx_q   <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            mem_clear_q <= 1'b0;
            mem_we_q    <= 1'b0;
            core_hold_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            mem_clear_q <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        ww_q        <= '0;
                        len_q       <= '0;
                        tmo_q       <= '0;
                        hdr_idx_q   <= '0;
                        byte_idx_q  <= '0;
                        word_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q       <= '0;
`endif
                        mem_clear_q <= 1'b1;
                        core_hold_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_CLEAR;
                    end
                end
                S_CLEAR: state_q <= S_HEADER;
                S_HEADER: begin
                    if (bus.rx_valid) begin
                        tmo_q <= '0;
                        len_q <= len_d;
                        if (hdr_idx_q == 3'(LEN_BYTES - 1)) begin
                            if (len_d == 32'd0) begin
                                done_q      <= 1'b1;
                                core_hold_q <= 1'b0;
                                state_q     <= S_DONE;
                            end else if (len_d > 32'(DEPTH)) begin
                                error_q     <= 1'b1;
                                core_hold_q <= 1'b0;
                                state_q     <= S_ERROR;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end else begin
                            hdr_idx_q <= hdr_idx_q + 3'd1;
                        end
                    end else if (hdr_idx_q != 3'd0) begin
                        if (tmo_hit) begin
                            error_q     <= 1'b1;
                            core_hold_q <= 1'b0;
                            state_q     <= S_ERROR;
                        end else begin
                            tmo_q <= tmo_q + 32'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        tmo_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q <= sum_q + bus.rx_data;
`endif
                        if (byte_idx_q == 4'(NB - 1)) begin
                            mem_we_q   <= 1'b1;
                            wdata_q    <= word_d;
                            addr_q     <= addr_d;
                            ww_q       <= ww_q + 32'd1;
                            word_q     <= '0;
                            byte_idx_q <= '0;
                            if (ww_q + 32'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q <= S_CHECK;
`else
                                done_q      <= 1'b1;
                                core_hold_q <= 1'b0;
                                state_q     <= S_DONE;
`endif
                            end
                        end else begin
                            word_q     <= word_d;
                            byte_idx_q <= byte_idx_q + 4'd1;
                        end
                    end else if (tmo_hit) begin
                        error_q     <= 1'b1;
                        core_hold_q <= 1'b0;
                        state_q     <= S_ERROR;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (bus.rx_valid) begin
                        core_hold_q <= 1'b0;
                        if (bus.rx_data == sum_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_ERROR;
                        end
                    end else if (tmo_hit) begin
                        error_q     <= 1'b1;
                        core_hold_q <= 1'b0;
                        state_q     <= S_ERROR;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
`endif
                S_DONE, S_ERROR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_clear   = mem_clear_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign core_hold_o     = core_hold_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign words_written_o = ww_q;
endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - randomized model-checked bench for uart_program_loader (big- and little-endian instances)
module tb_uart_program_loader;
    localparam int MEM_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, start, rx_valid;
    logic [7:0]  rx_data;
    logic        hold_a, busy_a, done_a, err_a;
    logic        hold_b, busy_b, done_b, err_b;
    logic [31:0] ww_a, ww_b;

    int checks = 0;
    int failures = 0;
    int clr_a = 0;
    int clr_b = 0;
    int exp_done, exp_err, exp_ww;
    logic [7:0]  exp_cks;
    logic [63:0] exp_a_addr[$], exp_a_data[$], exp_b_addr[$], exp_b_data[$];
    logic [63:0] obs_a_data[$], obs_b_data[$];

    uart_program_loader_if #(.WORD_W(32), .ADDR_W(32)) if_a ();
    uart_program_loader_if #(.WORD_W(32), .ADDR_W(16)) if_b ();

    assign if_a.rx_data  = rx_data;
    assign if_a.rx_valid = rx_valid;
    assign if_b.rx_data  = rx_data;
    assign if_b.rx_valid = rx_valid;

    uart_program_loader #(.WORD_W(32), .DEPTH(MEM_DEPTH), .ADDR_W(32), .BASE_ADDR(64'd0),
        .BIG_ENDIAN(1'b1), .LEN_BYTES(2), .TIMEOUT_CYCLES(100)) dut_a (
        .clk(clk), .rst(rst), .start_i(start), .bus(if_a), .core_hold_o(hold_a),
        .busy_o(busy_a), .done_o(done_a), .error_o(err_a), .words_written_o(ww_a));

    uart_program_loader #(.WORD_W(32), .DEPTH(MEM_DEPTH), .ADDR_W(16), .BASE_ADDR(64'h100),
        .BIG_ENDIAN(1'b0), .LEN_BYTES(2), .TIMEOUT_CYCLES(100)) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .bus(if_b), .core_hold_o(hold_b),
        .busy_o(busy_b), .done_o(done_b), .error_o(err_b), .words_written_o(ww_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit may_start);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
        for (int i = 0; i < gap; i++) begin
            start = may_start && ($urandom_range(0, 3) == 0);
            tick();
            start = 1'b0;
        end
    endtask

    task automatic begin_session();
        rx_valid = 1'b1; rx_data = 8'h33; tick();
        rx_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
        rx_valid = 1'b1; rx_data = 8'hFF; tick(); rx_valid = 1'b0;
    endtask

    task automatic model_session(input int len_val, input bit good, input logic [7:0] d[$]);
        int nw;
        logic [7:0] sum;
        logic [31:0] be, le;
        nw  = (len_val >= 1 && len_val <= MEM_DEPTH) ? len_val : 0;
        sum = 8'd0;
        foreach (d[i]) sum = sum + d[i];
        for (int w = 0; w < nw; w++) begin
            be = {d[4*w], d[4*w+1], d[4*w+2], d[4*w+3]};
            le = {d[4*w+3], d[4*w+2], d[4*w+1], d[4*w]};
            exp_a_addr.push_back(64'(4 * w));
            exp_a_data.push_back(64'(be));
            exp_b_addr.push_back(64'((32'h100 + 4 * w) & 32'hFFFF));
            exp_b_data.push_back(64'(le));
        end
        exp_ww = nw;
        if (len_val == 0) exp_done = 1;
        else if (len_val > MEM_DEPTH) exp_done = 0;
        else begin
`ifdef LOADER_CHECKSUM_EN
            exp_done = good ? 1 : 0;
`else
            exp_done = 1;
`endif
        end
        exp_err = exp_done ? 0 : 1;
        exp_cks = good ? sum : sum + 8'd1;
    endtask

    task automatic drive_session(input int len_val, input logic [7:0] d[$], input int max_gap);
        begin_session();
        send(len_val[7:0], $urandom_range(0, max_gap), 1'b0);
        send(len_val[15:8], $urandom_range(0, max_gap), 1'b0);
        for (int i = 0; i < d.size(); i++)
            send(d[i], $urandom_range(0, max_gap), i != d.size() - 1);
        if (d.size() != 0) send(exp_cks, $urandom_range(0, max_gap), 1'b0);
    endtask

    task automatic finish_session(input string tag);
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL %s_busy_wait actual=busy required=idle", tag);
        end
        @(negedge clk);
        chk({tag, "_done_a"}, 64'(done_a), 64'(exp_done));
        chk({tag, "_err_a"},  64'(err_a),  64'(exp_err));
        chk({tag, "_ww_a"},   64'(ww_a),   64'(exp_ww));
        chk({tag, "_hold_a"}, 64'(hold_a), 64'd0);
        chk({tag, "_done_b"}, 64'(done_b), 64'(exp_done));
        chk({tag, "_err_b"},  64'(err_b),  64'(exp_err));
        chk({tag, "_ww_b"},   64'(ww_b),   64'(exp_ww));
        chk({tag, "_pending_a"}, 64'(exp_a_addr.size()), 64'd0);
        chk({tag, "_pending_b"}, 64'(exp_b_addr.size()), 64'd0);
        chk({tag, "_clears_a"}, 64'(clr_a), 64'd1);
        chk({tag, "_clears_b"}, 64'(clr_b), 64'd1);
        exp_a_addr.delete(); exp_a_data.delete();
        exp_b_addr.delete(); exp_b_data.delete();
        clr_a = 0;
        clr_b = 0;
        tick();
    endtask

    initial begin
        logic [7:0] d[$];
        int len_val;
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (if_a.mem_we) begin
                    obs_a_data.push_back(64'(if_a.mem_wdata));
                    if (exp_a_addr.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL a_unexpected_write actual=write@0x%0h required=no_write", if_a.mem_addr);
                    end else begin
                        chk("a_addr", 64'(if_a.mem_addr), exp_a_addr.pop_front());
                        chk("a_data", 64'(if_a.mem_wdata), exp_a_data.pop_front());
                    end
                end
                if (if_b.mem_we) begin
                    obs_b_data.push_back(64'(if_b.mem_wdata));
                    if (exp_b_addr.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL b_unexpected_write actual=write@0x%0h required=no_write", if_b.mem_addr);
                    end else begin
                        chk("b_addr", 64'(if_b.mem_addr), exp_b_addr.pop_front());
                        chk("b_data", 64'(if_b.mem_wdata), exp_b_data.pop_front());
                    end
                end
                if (if_a.mem_clear) begin
                    clr_a++;
                    chk("a_hold_at_clear", 64'(hold_a), 64'd1);
                end
                if (if_b.mem_clear) clr_b++;
            end
        join_none

        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy_a",  64'(busy_a), 64'd0);
        chk("rst_hold_a",  64'(hold_a), 64'd0);
        chk("rst_done_a",  64'(done_a), 64'd0);
        chk("rst_err_a",   64'(err_a),  64'd0);
        chk("rst_ww_a",    64'(ww_a),   64'd0);
        chk("rst_we_a",    64'(if_a.mem_we), 64'd0);
        chk("rst_clear_a", 64'(if_a.mem_clear), 64'd0);
        chk("rst_busy_b",  64'(busy_b), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reference stream: two words
        d = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        obs_a_data.delete(); obs_b_data.delete();
        model_session(2, 1'b1, d);
        drive_session(2, d, 0);
        finish_session("s1");
        chk("s1_obs_count_a", 64'(obs_a_data.size()), 64'd2);
        chk("s1_obs_count_b", 64'(obs_b_data.size()), 64'd2);
        if (obs_a_data.size() >= 2 && obs_b_data.size() >= 2) begin
            chk("s1_lit_a0", obs_a_data[0], 64'h12345678);
            chk("s1_lit_a1", obs_a_data[1], 64'hAABBCCDD);
            chk("s1_lit_b0", obs_b_data[0], 64'h78563412);
            chk("s1_lit_b1", obs_b_data[1], 64'hDDCCBBAA);
        end

        // Zero-length header
        d.delete();
        model_session(0, 1'b1, d);
        begin_session();
        send(8'h00, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("zero_done_a3", 64'(done_a), 64'd1);
        chk("zero_busy_a3", 64'(busy_a), 64'd0);
        chk("zero_hold_a3", 64'(hold_a), 64'd0);
        chk("zero_done_b3", 64'(done_b), 64'd1);
        @(posedge clk); #1;
        finish_session("zero");

        // Length beyond memory depth
        model_session(5, 1'b1, d);
        drive_session(5, d, 2);
        finish_session("depth");
        chk("depth_lit_err_a", 64'(err_a), 64'd1);

        // Inter-byte timeout with a partial word pending
        exp_done = 0; exp_err = 1; exp_ww = 0;
        begin_session();
        send(8'h01, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        send(8'h12, 0, 1'b0);
        send(8'h34, 0, 1'b0);
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 99) begin
                chk("tmo_99_err_a", 64'(err_a), 64'd0);
                chk("tmo_99_hold_a", 64'(hold_a), 64'd1);
            end
            if (c == 100) begin
                chk("tmo_100_err_a", 64'(err_a), 64'd1);
                chk("tmo_100_err_b", 64'(err_b), 64'd1);
            end
        end
        @(posedge clk); #1;
        finish_session("timeout");

        // Checksum good and bad on one word
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        obs_a_data.delete();
        model_session(1, 1'b1, d);
        drive_session(1, d, 1);
        finish_session("cks_good");
        chk("cks_good_obs_count", 64'(obs_a_data.size()), 64'd1);
        if (obs_a_data.size() >= 1) chk("cks_good_lit_word", obs_a_data[0], 64'h01020304);
        chk("cks_good_lit_done", 64'(done_a), 64'd1);
        obs_a_data.delete();
        model_session(1, 1'b0, d);
        drive_session(1, d, 1);
        finish_session("cks_bad");
        chk("cks_bad_obs_count", 64'(obs_a_data.size()), 64'd1);
        if (obs_a_data.size() >= 1) chk("cks_bad_lit_word", obs_a_data[0], 64'h01020304);
`ifdef LOADER_CHECKSUM_EN
        chk("cks_bad_lit_err", 64'(err_a), 64'd1);
`else
        chk("cks_bad_lit_done", 64'(done_a), 64'd1);
`endif

        // Randomized sessions
        for (int s = 0; s < 30; s++) begin
            len_val = $urandom_range(0, 6);
            if (len_val == 6) len_val = 257;
            d.delete();
            if (len_val >= 1 && len_val <= MEM_DEPTH)
                for (int i = 0; i < 4 * len_val; i++) d.push_back(8'($urandom_range(0, 255)));
            model_session(len_val, 1'($urandom_range(0, 1)), d);
            drive_session(len_val, d, 3);
            finish_session($sformatf("rnd%0d", s));
        end

        // Reset in the middle of a session
        d.delete();
        for (int i = 0; i < 12; i++) d.push_back(8'($urandom_range(0, 255)));
        model_session(3, 1'b1, d);
        while (exp_a_addr.size() > 1) begin
            void'(exp_a_addr.pop_back()); void'(exp_a_data.pop_back());
            void'(exp_b_addr.pop_back()); void'(exp_b_data.pop_back());
        end
        exp_done = 0; exp_err = 0; exp_ww = 0;
        begin_session();
        send(8'h03, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        for (int i = 0; i < 5; i++) send(d[i], 0, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rstmid_hold_a", 64'(hold_a), 64'd0);
        chk("rstmid_busy_a", 64'(busy_a), 64'd0);
        chk("rstmid_ww_a",   64'(ww_a),   64'd0);
        chk("rstmid_hold_b", 64'(hold_b), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 5; i < 12; i++) send(d[i], 0, 1'b0);
        finish_session("rstmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
